// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the 5-stage 16-bit CPU, with WB->ID bypass and load-use bubble insertion.
// Latency: ID->EX is 1 cycle; a load-use pair costs 2 cycles (one bubble).
// Backpressure: ex_ready=0 freezes all EX registers and raises id_stall; flush overrides both hold and hazard.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   id_valid/src1/src2/dst/wen/memrd/data1/data2/imm   decode-slot instruction and register file operands
//   ex_ready                      EX can accept an instruction this cycle
//   flush                         branch/jump redirect, kills the EX slot
//   wb_dst/wb_wen/wb_data         writeback port, bypassed into the captured operands
//   id_stall                      combinational hold request for IF/ID and PC
//   ex_*                          registered EX-stage instruction fields
//   bubble_cnt                    saturating count of load-use bubbles (only with ID_EX_BUBBLE_COUNT_EN)
//
// Build option: define ID_EX_BUBBLE_COUNT_EN to add the bubble_cnt output.
module id_ex_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_memrd,
  input  logic [DATA_W-1:0] id_data1,
  input  logic [DATA_W-1:0] id_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_wen,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_src1,
  output logic [REG_AW-1:0] ex_src2,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_wen,
  output logic              ex_memrd,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } stateT;

  stateT             state;
  logic              hazard;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;

  // A load in EX whose result is needed by the decode-slot instruction.
  // While a bubble sits in EX, ex_valid=0 so at most one bubble per load.
  assign hazard = id_valid & ex_valid & ex_memrd & ex_wen & (ex_dst != '0) &
                  ((ex_dst == id_src1) | (ex_dst == id_src2));

  assign id_stall = hazard | ~ex_ready;

  // The register file writes at the same edge we capture, so a matching
  // writeback must be forwarded; r0 always reads as zero.
  always_comb begin
    operand1 = id_data1;
    if (id_src1 == '0)
      operand1 = '0;
    else if (wb_wen && (wb_dst == id_src1))
      operand1 = wb_data;
  end

  always_comb begin
    operand2 = id_data2;
    if (id_src2 == '0)
      operand2 = '0;
    else if (wb_wen && (wb_dst == id_src2))
      operand2 = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      ex_valid <= 1'b0;
      ex_src1  <= '0;
      ex_src2  <= '0;
      ex_dst   <= '0;
      ex_wen   <= 1'b0;
      ex_memrd <= 1'b0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
    end else if (flush) begin
      // Data fields are left as-is; they are meaningless once ex_valid drops.
      state    <= RUN;
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
      ex_memrd <= 1'b0;
    end else if (!ex_ready) begin
      state <= HOLD;
    end else if (hazard) begin
      // Bubble into EX; the ID instruction stays upstream via id_stall.
      state    <= BUBBLE;
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
      ex_memrd <= 1'b0;
    end else begin
      state    <= RUN;
      ex_valid <= id_valid;
      ex_src1  <= id_src1;
      ex_src2  <= id_src2;
      ex_dst   <= id_dst;
      ex_wen   <= id_wen;
      ex_memrd <= id_memrd;
      ex_data1 <= operand1;
      ex_data2 <= operand2;
      ex_imm   <= id_imm;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (!flush && ex_ready && hazard && (bubble_cnt != 16'hFFFF))
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed cases plus randomized traffic against a reference model.
// Latency: checks id_stall combinationally before each edge and ex_* one cycle after.
// Backpressure: exercises ex_ready holds, flushes and load-use stalls.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid, idWen, idMemrd, exReady, flushIn, wbWen;
  logic [3:0]  idSrc1, idSrc2, idDst, wbDst;
  logic [15:0] idData1, idData2, idImm, wbData;
  logic        idStall, exValid, exWen, exMemrd;
  logic [3:0]  exSrc1, exSrc2, exDst;
  logic [15:0] exData1, exData2, exImm;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubbleCnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the EX slot
  logic        mValid, mWen, mMemrd;
  logic [3:0]  mSrc1, mSrc2, mDst;
  logic [15:0] mData1, mData2, mImm;
  int          mBubbles;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst),
    .id_valid(idValid), .id_src1(idSrc1), .id_src2(idSrc2), .id_dst(idDst),
    .id_wen(idWen), .id_memrd(idMemrd), .id_data1(idData1), .id_data2(idData2),
    .id_imm(idImm), .ex_ready(exReady), .flush(flushIn),
    .wb_dst(wbDst), .wb_wen(wbWen), .wb_data(wbData),
    .id_stall(idStall), .ex_valid(exValid), .ex_src1(exSrc1), .ex_src2(exSrc2),
    .ex_dst(exDst), .ex_wen(exWen), .ex_memrd(exMemrd),
    .ex_data1(exData1), .ex_data2(exData2), .ex_imm(exImm)
`ifdef ID_EX_BUBBLE_COUNT_EN
    , .bubble_cnt(bubbleCnt)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] expOperand(input logic [3:0] src, input logic [15:0] rf);
    if (src == 4'd0) return 16'h0;
    if (wbWen && wbDst == src) return wbData;
    return rf;
  endfunction

  function automatic logic expHazard();
    return idValid && mValid && mMemrd && mWen && mDst != 4'd0 &&
           (mDst == idSrc1 || mDst == idSrc2);
  endfunction

  task automatic modelReset();
    mValid = 0; mWen = 0; mMemrd = 0;
    mSrc1 = 0; mSrc2 = 0; mDst = 0; mData1 = 0; mData2 = 0; mImm = 0;
    mBubbles = 0;
  endtask

  task automatic checkEx();
    checkVal("ex_valid", exValid, mValid);
    checkVal("ex_wen", exWen, mWen);
    checkVal("ex_memrd", exMemrd, mMemrd);
    if (mValid) begin
      checkVal("ex_src1", exSrc1, mSrc1);
      checkVal("ex_src2", exSrc2, mSrc2);
      checkVal("ex_dst", exDst, mDst);
      checkVal("ex_data1", exData1, mData1);
      checkVal("ex_data2", exData2, mData2);
      checkVal("ex_imm", exImm, mImm);
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    checkVal("bubble_cnt", bubbleCnt, mBubbles);
`endif
  endtask

  // Inputs are already driven; check id_stall, clock once, advance model, check EX.
  task automatic applyCycle();
    logic hz;
    #1;
    hz = expHazard();
    checkVal("id_stall", idStall, hz || !exReady);
    if (flushIn) begin
      mValid = 0; mWen = 0; mMemrd = 0;
    end else if (!exReady) begin
      // frozen
    end else if (hz) begin
      mValid = 0; mWen = 0; mMemrd = 0;
      if (mBubbles < 16'hFFFF) mBubbles++;
    end else begin
      mValid = idValid; mWen = idWen; mMemrd = idMemrd;
      mSrc1 = idSrc1; mSrc2 = idSrc2; mDst = idDst; mImm = idImm;
      mData1 = expOperand(idSrc1, idData1);
      mData2 = expOperand(idSrc2, idData2);
    end
    @(posedge clk);
    #1;
    checkEx();
  endtask

  task automatic idle();
    idValid = 0; idWen = 0; idMemrd = 0; exReady = 1; flushIn = 0; wbWen = 0;
    idSrc1 = 0; idSrc2 = 0; idDst = 0; wbDst = 0;
    idData1 = 0; idData2 = 0; idImm = 0; wbData = 0;
  endtask

  task automatic driveInstr(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                            input logic w, input logic ld);
    idValid = 1; idSrc1 = s1; idSrc2 = s2; idDst = d; idWen = w; idMemrd = ld;
    idData1 = 16'($urandom); idData2 = 16'($urandom); idImm = 16'($urandom);
  endtask

  initial begin
    int stallCycles;
    logic [15:0] frozen;
    idle();
    rst = 1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkEx();
    checkVal("rst id_stall", idStall, 0);
    rst = 0;

    // Plain flow
    driveInstr(4'd3, 4'd1, 4'd2, 1'b1, 1'b0);
    idData1 = 16'h1234; idImm = 16'hFFF0;
    applyCycle();
    checkVal("plain ex_data1", exData1, 16'h1234);
    checkVal("plain ex_imm", exImm, 16'hFFF0);
    checkVal("plain ex_valid", exValid, 1);

    // WB bypass on src2, r0 on src1 with a wb to r0
    driveInstr(4'd1, 4'd5, 4'd6, 1'b1, 1'b0);
    idData2 = 16'h0000; wbWen = 1; wbDst = 4'd5; wbData = 16'hBEEF;
    applyCycle();
    checkVal("bypass ex_data2", exData2, 16'hBEEF);
    driveInstr(4'd0, 4'd2, 4'd6, 1'b1, 1'b0);
    idData1 = 16'h5555; wbWen = 1; wbDst = 4'd0; wbData = 16'hAAAA;
    applyCycle();
    checkVal("r0 ex_data1", exData1, 16'h0000);
    wbWen = 0;

    // Load-use: load r4, then consumer of r4
    driveInstr(4'd1, 4'd2, 4'd4, 1'b1, 1'b1);
    applyCycle();
    driveInstr(4'd4, 4'd7, 4'd8, 1'b1, 1'b0);
    stallCycles = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (idStall) stallCycles++;
      #0;
      if (i == 1) checkVal("loaduse bubble ex_valid", exValid, 0);
      applyCycle();
      if (i == 1) checkVal("loaduse consumer ex_src1", exSrc1, 4'd4);
    end
    checkVal("loaduse stall cycles", stallCycles, 1);
`ifdef ID_EX_BUBBLE_COUNT_EN
    checkVal("loaduse bubble_cnt", bubbleCnt, 1);
`endif

    // EX hold for 3 cycles
    frozen = exData1;
    driveInstr(4'd9, 4'd10, 4'd11, 1'b1, 1'b0);
    exReady = 0;
    for (int i = 0; i < 3; i++) begin
      applyCycle();
      checkVal("hold id_stall", idStall, 1);
      checkVal("hold ex_data1", exData1, frozen);
    end

    // Flush overrides hold
    flushIn = 1;
    applyCycle();
    checkVal("flush+hold ex_valid", exValid, 0);
    flushIn = 0; exReady = 1;

    // Flush overrides hazard: no bubble counted
    driveInstr(4'd1, 4'd2, 4'd4, 1'b1, 1'b1);
    applyCycle();
    driveInstr(4'd4, 4'd3, 4'd5, 1'b1, 1'b0);
    flushIn = 1;
    applyCycle();
    flushIn = 0;

    // Reset in the middle of a load-use stall
    driveInstr(4'd1, 4'd2, 4'd4, 1'b1, 1'b1);
    applyCycle();
    driveInstr(4'd4, 4'd3, 4'd5, 1'b1, 1'b0);
    #2;
    rst = 1;
    modelReset();
    #1;
    checkVal("async rst ex_valid", exValid, 0);
    checkVal("async rst id_stall", idStall, 0);
    @(posedge clk);
    #1;
    checkEx();
    rst = 0;

    // Randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 400; n++) begin
      driveInstr(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      idValid = ($urandom_range(0, 7) != 0);
      exReady = ($urandom_range(0, 4) != 0);
      flushIn = ($urandom_range(0, 19) == 0);
      wbWen   = $urandom_range(0, 1);
      wbDst   = 4'($urandom_range(0, 5));
      wbData  = 16'($urandom);
      applyCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline stage for the 5-stage 16-bit CPU, directly downstream of the 16x16 register file.
- Captures the two source operands, the immediate and the control fields into EX-stage registers.
- Applies a WB->ID bypass for same-cycle writes.
- Detects load-use hazards, inserts one bubble, and honours a downstream stall and a flush.

Parameters:
- DATA_W, 16, operand/immediate width
- REG_AW, 4, register index width (16 registers, r0 hardwired zero)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode slot holds an instruction
- id_src1  in  REG_AW  source register 1 index
- id_src2  in  REG_AW  source register 2 index
- id_dst  in  REG_AW  destination index
- id_wen  in  1  instruction writes a register
- id_memrd  in  1  instruction is a load
- id_data1  in  DATA_W  register file SrcData1
- id_data2  in  DATA_W  register file SrcData2
- id_imm  in  DATA_W  sign-extended immediate
- ex_ready  in  1  EX can accept a new instruction this cycle
- flush  in  1  branch/jump redirect; kill ID and EX contents
- wb_dst  in  REG_AW  writeback destination
- wb_wen  in  1  writeback write enable
- wb_data  in  DATA_W  writeback data
- id_stall  out  1  hold IF/ID and PC this cycle
- ex_valid  out  1  EX slot valid
- ex_src1, ex_src2, ex_dst  out  REG_AW  registered indices
- ex_wen, ex_memrd  out  1  registered controls
- ex_data1, ex_data2, ex_imm  out  DATA_W  registered operands

Behaviour:
- Reset: all ex_* outputs and the FSM are cleared to 0 / RUN immediately on rst=1, independent of clk. id_stall=0.
- FSM states:
  - RUN: normal flow.
  - HOLD: ex_ready was low; outputs are frozen.
  - BUBBLE: a load-use bubble was issued last cycle.
  - Transitions:
    - any state -> HOLD when ex_ready=0 and flush=0
    - HOLD -> RUN when ex_ready=1
    - RUN -> BUBBLE when hazard=1 and ex_ready=1
    - BUBBLE -> RUN on the next accepted cycle
- hazard = id_valid & ex_valid & ex_memrd & ex_wen & (ex_dst!=0) & (ex_dst==id_src1 | ex_dst==id_src2).
- id_stall = hazard | ~ex_ready. It is combinational, with zero-cycle latency.
- Capture, on the rising edge, in priority order:
  1. flush=1: ex_valid<=0, ex_wen<=0, ex_memrd<=0; data fields don't-care. Flush overrides ex_ready=0 and hazard.
  2. ex_ready=0: all ex_* hold.
  3. hazard=1: a bubble is captured (ex_valid<=0, ex_wen<=0, ex_memrd<=0); the ID instruction is retained upstream via id_stall.
  4. Otherwise: all id_* are captured; ex_valid<=id_valid.
- Operand select for operand n (n = 1, 2):
  - If src_n==0, the captured value is 0.
  - Else if wb_wen & wb_dst==src_n, the captured value is wb_data (bypass, because the register file updates at the same edge).
  - Else the captured value is id_data_n.
- A hazard re-evaluated while in BUBBLE sees ex_valid=0, so at most one bubble is inserted per load.
- Latency: ID->EX is 1 cycle; a load-use pair costs 2 cycles.
- Reset asserted mid-stall or mid-bubble returns to RUN with ex_valid=0 and no residual stall.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- Defined:
  - Adds output bubble_cnt [15:0].
  - Increments when a hazard bubble is captured (not for flush or hold).
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles mid-operation with ex_valid=1 -> all ex_*=0 immediately, id_stall=0, FSM=RUN.
- Plain flow: id_src1=3, id_data1=16'h1234, id_imm=16'hFFF0, id_valid=1, ex_ready=1 -> next cycle ex_data1=16'h1234, ex_imm=16'hFFF0, ex_valid=1.
- WB bypass and r0:
  - Case 1: wb_wen=1, wb_dst=5, wb_data=16'hBEEF, id_src2=5, id_data2=16'h0000 -> ex_data2=16'hBEEF.
  - Case 2: wb_dst=0, id_src1=0 -> ex_data1=0.
- Load-use:
  - Stimulus: load r4 in EX, ID instruction id_src1=4 -> id_stall=1 for exactly 1 cycle, then ex_valid=0 for 1 cycle; the ID instruction then enters EX.
  - With ID_EX_BUBBLE_COUNT_EN: bubble_cnt 0->1.
- Stall and flush:
  - ex_ready=0 for 3 cycles -> ex_* frozen and id_stall=1 throughout.
  - flush=1 with ex_ready=0 -> ex_valid=0 next cycle.
  - flush=1 with hazard=1 -> no increment of bubble_cnt.
